// File: rtl/fpu_rnd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fpu_rnd_pkg
// Description : Shared widths and types for the rounder datapath.
//               These are used by sigdenormshift, signormshift and the rounder.
//               Exports:
//                 FR_W, SH_W  significand / shift-distance widths
//                 sig_t       FR_W-bit significand
//                 shamt_t     SH_W-bit unsigned shift distance
//                 clamp_dist  saturates a shift distance to DIST_MAX
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_rnd_pkg;

  localparam int FR_W = 57;
  localparam int SH_W = 13;

  // Internal shift distance. It is 6 bits wide, so it saturates at 63.
  // 63 >= FR_W, so a saturated shift still flushes every significand bit.
  localparam int             DIST_W   = 6;
  localparam logic [DIST_W-1:0] DIST_MAX = 6'd63;

  typedef logic [FR_W-1:0] sig_t;
  typedef logic [SH_W-1:0] shamt_t;

  // Returns min(sh, 63).
  function automatic logic [DIST_W-1:0] clamp_dist(input shamt_t sh);
    if (|sh[SH_W-1:DIST_W]) begin
      return DIST_MAX;
    end
    return sh[DIST_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sticky_rshift_stage.sv
`default_nettype none
// ============================================================================
// Module      : sticky_rshift_stage
// Description : Combinational right shift by amt_i*STEP.
//               Every bit shifted out is ORed into the sticky output.
//               The sticky_i input lets stages be chained.
// Ports       : din_i     W     data to shift
//               amt_i     BITS  shift amount, in units of STEP bits
//               sticky_i  1     sticky carried in from an earlier stage
//               dout_o    W     shifted data (sticky is not merged here)
//               sticky_o  1     sticky_i OR any dropped bit
// Revision    : 1.0 - initial release
// ============================================================================
module sticky_rshift_stage
  import fpu_rnd_pkg::*;
#(
  parameter int W    = FR_W,
  parameter int STEP = 1,
  parameter int BITS = 3
) (
  input  logic [W-1:0]    din_i,
  input  logic [BITS-1:0] amt_i,
  input  logic            sticky_i,
  output logic [W-1:0]    dout_o,
  output logic            sticky_o
);

  int w_shamt;

  always_comb begin
    w_shamt  = int'(amt_i) * STEP;
    dout_o   = din_i >> w_shamt;
    sticky_o = sticky_i;
    // Every position below the shift distance falls off the bottom.
    for (int i = 0; i < W; i++) begin
      if (i < w_shamt) begin
        sticky_o = sticky_o | din_i[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sigdenormshift.sv
`default_nettype none
// ============================================================================
// Module      : sigdenormshift
// Description : Sticky-preserving right (denormalising) shifter.
//               It is a 2-stage elastic pipeline with valid/ready on both
//               sides.
//                 S1 shifts by multiples of 8 (d[5:3]).
//                 S2 shifts by d[2:0] and merges sticky into the LSB.
// Ports       : clk        1     clock, rising edge
//               rst        1     asynchronous active-high reset
//               in_valid   1     fr/sh valid
//               in_ready   1     input accepted this cycle
//               fr         FR_W  significand
//               sh         SH_W  unsigned right-shift distance
//               out_valid  1     fd/inexact valid
//               out_ready  1     consumer accepts this cycle
//               fd         FR_W  shifted significand, sticky in bit 0
//               inexact    1     a nonzero bit was shifted out
// Revision    : 1.0 - initial release
// ============================================================================
module sigdenormshift
  import fpu_rnd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  sig_t   fr,
  input  shamt_t sh,
  output logic   out_valid,
  input  logic   out_ready,
  output sig_t   fd,
  output logic   inexact
);

  logic [DIST_W-1:0] w_dist;
  sig_t              w_s1_data;
  logic              w_s1_sticky;
  sig_t              w_s2_data;
  logic              w_s2_sticky;
  logic              w_s1_adv;
  logic              w_s2_adv;

  // Stage 1 registers
  logic       s1_valid_q,  s1_valid_d;
  sig_t       s1_data_q,   s1_data_d;
  logic       s1_sticky_q, s1_sticky_d;
  logic [2:0] s1_amt_q,    s1_amt_d;

  // Output (stage 2) registers
  logic       out_valid_q, out_valid_d;
  sig_t       fd_q,        fd_d;
  logic       inexact_q,   inexact_d;

  assign w_dist = clamp_dist(sh);

  sticky_rshift_stage #(
    .W    (FR_W),
    .STEP (8),
    .BITS (3)
  ) u_stage1 (
    .din_i    (fr),
    .amt_i    (w_dist[5:3]),
    .sticky_i (1'b0),
    .dout_o   (w_s1_data),
    .sticky_o (w_s1_sticky)
  );

  sticky_rshift_stage #(
    .W    (FR_W),
    .STEP (1),
    .BITS (3)
  ) u_stage2 (
    .din_i    (s1_data_q),
    .amt_i    (s1_amt_q),
    .sticky_i (s1_sticky_q),
    .dout_o   (w_s2_data),
    .sticky_o (w_s2_sticky)
  );

  // Back-pressure ripples from the output to the input.
  // in_ready does not depend on in_valid.
  assign w_s2_adv = !out_valid_q || out_ready;
  assign w_s1_adv = !s1_valid_q || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_sticky_d = s1_sticky_q;
    s1_amt_d    = s1_amt_q;
    out_valid_d = out_valid_q;
    fd_d        = fd_q;
    inexact_d   = inexact_q;

    // Data registers only load with a valid word, so no X enters the pipe.
    if (w_s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d   = w_s1_data;
        s1_sticky_d = w_s1_sticky;
        s1_amt_d    = w_dist[2:0];
      end
    end

    if (w_s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        fd_d      = w_s2_data | {{(FR_W-1){1'b0}}, w_s2_sticky};
        inexact_d = w_s2_sticky;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_sticky_q <= 1'b0;
      s1_amt_q    <= '0;
      out_valid_q <= 1'b0;
      fd_q        <= '0;
      inexact_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_sticky_q <= s1_sticky_d;
      s1_amt_q    <= s1_amt_d;
      out_valid_q <= out_valid_d;
      fd_q        <= fd_d;
      inexact_q   <= inexact_d;
    end
  end

  assign out_valid = out_valid_q;
  assign fd        = fd_q;
  assign inexact   = inexact_q;

endmodule
`default_nettype wire

// File: tb/tb_sigdenormshift.sv
`default_nettype none
// ============================================================================
// Module      : tb_sigdenormshift
// Description : Scoreboard bench for sigdenormshift.
//               Directed vectors, back-pressure, reset mid-flight and random
//               words are driven against a bit-loop reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sigdenormshift;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [56:0] fr;
  logic [12:0] sh;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [56:0] fd;
  logic        inexact;

  sigdenormshift dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fr        (fr),
    .sh        (sh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fd        (fd),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [56:0] fd;
    logic        inx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_val  = 1'b1;

  // Directed vectors: fr, sh, expected fd, expected inexact.
  logic [56:0] t_fr [0:13] = '{
    57'h123456789ABCDEF, 57'h123456789ABCDEF, 57'h100,  57'h123456789ABCDEF,
    57'h0,               57'h1FFFFFFFFFFFFFF, 57'h100000000000000,
    57'h100000000000000, 57'h1FF,             57'h180,
    57'h100000000000000, 57'hF0,              57'hABCD, 57'h123456789ABCDEF};
  logic [12:0] t_sh [0:13] = '{
    13'd0, 13'd4, 13'd8, 13'd57, 13'h1FFF, 13'd56, 13'd56,
    13'd63, 13'd9, 13'd7, 13'd64, 13'd3, 13'd5, 13'd1000};
  logic [56:0] t_fd [0:13] = '{
    57'h123456789ABCDEF, 57'h123456789ABCDF, 57'h1, 57'h1,
    57'h0,               57'h1,              57'h1,
    57'h1,               57'h1,              57'h3,
    57'h1,               57'h1E,             57'h55F, 57'h1};
  logic        t_inx [0:13] = '{
    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  // out_ready changes 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at a falling edge transfers on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got fd=%h expected no output", fd);
      end else begin
        mon_e = sb.pop_front();
        check("fd", 64'(fd), 64'(mon_e.fd));
        check("inexact", 64'(inexact), 64'(mon_e.inx));
      end
    end
  end

  function automatic void model(input logic [56:0] f, input logic [12:0] s,
                                output logic [56:0] efd, output logic einx);
    int d;
    logic lost;
    d    = (s > 13'd63) ? 63 : int'(s);
    lost = 1'b0;
    for (int i = 0; i < 57; i++) begin
      if (i < d) lost = lost | f[i];
    end
    efd    = (d >= 57) ? 57'h0 : (f >> d);
    efd[0] = efd[0] | lost;
    einx   = lost;
  endfunction

  // Called at posedge+1. It returns at posedge+1 after the accepting edge.
  task automatic send(input logic [56:0] f, input logic [12:0] s,
                      input logic [56:0] efd, input logic einx);
    int t;
    bit done;
    t    = 0;
    done = 1'b0;
    in_valid = 1'b1;
    fr       = f;
    sh       = s;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp_t'{fd: efd, inx: einx});
        done = 1'b1;
      end else begin
        t++;
        if (t > 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected 1");
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [56:0] f, input logic [12:0] s);
    logic [56:0] efd;
    logic        einx;
    model(f, s, efd, einx);
    send(f, s, efd, einx);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [56:0] rf;
    logic [12:0] rs;
    rst      = 1'b1;
    in_valid = 1'b0;
    fr       = '0;
    sh       = '0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fd", 64'(fd), 64'd0);
    check("rst_inexact", 64'(inexact), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors, back to back
    for (int i = 0; i < 14; i++) begin
      send(t_fr[i], t_sh[i], t_fd[i], t_inx[i]);
    end
    drain();

    // Back-pressure: hold out_ready low and offer three words
    rdy_val = 1'b0;
    send(57'h123456789ABCDEF, 13'd4, 57'h123456789ABCDF, 1'b1);
    send(57'h100, 13'd8, 57'h1, 1'b0);
    in_valid = 1'b1;
    fr       = 57'hABCD;
    sh       = 13'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_fd_stable", 64'(fd), 64'(57'h123456789ABCDF));
      check("bp_inexact_stable", 64'(inexact), 64'd1);
      @(posedge clk);
      #1;
    end
    rdy_val = 1'b1;
    send(57'hABCD, 13'd5, 57'h55F, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_consecutive", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    drain();

    // Reset with two words in flight
    rdy_val = 1'b0;
    send(57'hF0, 13'd3, 57'h1E, 1'b0);
    send(57'h1FF, 13'd9, 57'h1, 1'b1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_fd", 64'(fd), 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rdy_val = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midrst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Random words with random gaps and random back-pressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      rf = 57'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) rs = 13'($urandom_range(0, 8191));
      else                           rs = 13'($urandom_range(0, 70));
      send_model(rf, rs);
    end
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
